// File: rtl/lut_neuron_stream.sv
`default_nettype none
// lut_neuron_stream: runtime-loadable 2^IN_W x OUT_W truth-table neuron with a 2-stage valid/ready lookup pipeline.
// Optional macro LUT_NEURON_INIT_EN: come out of reset in RUN.
module lut_neuron_stream #(
  parameter int IN_W      = 8,
  parameter int OUT_W     = 2,
  parameter     INIT_FILE = ""
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [IN_W-1:0]  s_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [OUT_W-1:0] m_data,
  input  logic             cfg_wr_en,
  input  logic [IN_W-1:0]  cfg_addr,
  input  logic [OUT_W-1:0] cfg_data,
  input  logic             cfg_commit,
  output logic             cfg_busy,
  output logic             cfg_err
);

  localparam int            DEPTH    = 1 << IN_W;
  localparam logic [IN_W:0] FULL_CNT = {1'b1, {IN_W{1'b0}}};
  localparam logic [IN_W:0] ONE_CNT  = {{IN_W{1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    LOAD  = 2'd1,
    RUN   = 2'd2
  } state_t;

`ifdef LUT_NEURON_INIT_EN
  localparam state_t RESET_STATE = RUN;
`else
  localparam state_t RESET_STATE = EMPTY;
`endif

  state_t          state;
  state_t          state_nxt;
  logic            full_req;
  logic            full_nxt;
  logic [IN_W:0]   wr_cnt;
  logic [IN_W:0]   cnt_nxt;
  logic            err_nxt;

  logic [OUT_W-1:0] mem [DEPTH];

  logic            v1;
  logic            v2;
  logic [IN_W-1:0] d1;
  logic            stall;
  logic            accept;

  always_ff @(posedge clk) begin
    if (cfg_wr_en) mem[cfg_addr] <= cfg_data;
  end

  // A write issued this cycle is folded into the count before a same-cycle commit is judged.
  always_comb begin
    cnt_nxt   = wr_cnt;
    full_nxt  = full_req;
    state_nxt = state;
    err_nxt   = cfg_err;
    if (cfg_wr_en && (state != LOAD)) begin
      cnt_nxt = ONE_CNT;
    end else if (cfg_wr_en && (wr_cnt != FULL_CNT)) begin
      cnt_nxt = wr_cnt + ONE_CNT;
    end
    if (cfg_wr_en && (state == EMPTY)) begin
      full_nxt = 1'b1;
    end else if (cfg_wr_en && (state == RUN)) begin
      full_nxt = 1'b0;
    end
    if ((state == LOAD) || cfg_wr_en) begin
      state_nxt = LOAD;
      if (cfg_commit) begin
        if (!full_nxt || (cnt_nxt == FULL_CNT)) begin
          state_nxt = RUN;
        end else begin
          state_nxt = EMPTY;
          err_nxt   = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= RESET_STATE;
      full_req <= 1'b0;
      wr_cnt   <= '0;
      cfg_err  <= 1'b0;
      cfg_busy <= (RESET_STATE != RUN);
    end else begin
      state    <= state_nxt;
      full_req <= full_nxt;
      wr_cnt   <= cnt_nxt;
      cfg_err  <= err_nxt;
      cfg_busy <= (state_nxt != RUN);
    end
  end

  assign stall   = v2 && !m_ready;
  assign s_ready = (state == RUN) && !stall && !cfg_wr_en;
  assign accept  = s_valid && s_ready;
  assign m_valid = v2;

  // Both stages advance together; a stalled output freezes the whole pipe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1     <= 1'b0;
      v2     <= 1'b0;
      d1     <= '0;
      m_data <= '0;
    end else if (!stall) begin
      v1 <= accept;
      if (accept) d1 <= s_data;
      v2 <= v1;
      if (v1) m_data <= mem[d1];
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_lut_neuron_stream.sv
`default_nettype none
// tb_lut_neuron_stream: directed self-checking bench for lut_neuron_stream (IN_W=8, OUT_W=2, default build).
module tb_lut_neuron_stream;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       s_valid;
  logic       s_ready;
  logic [7:0] s_data;
  logic       m_valid;
  logic       m_ready;
  logic [1:0] m_data;
  logic       cfg_wr_en;
  logic [7:0] cfg_addr;
  logic [1:0] cfg_data;
  logic       cfg_commit;
  logic       cfg_busy;
  logic       cfg_err;

  int checks = 0;
  int errors = 0;
  logic [1:0] tbl [256];

  lut_neuron_stream #(.IN_W(8), .OUT_W(2), .INIT_FILE("")) dut (
    .clk(clk), .rst_n(rst_n),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .cfg_wr_en(cfg_wr_en), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .cfg_commit(cfg_commit), .cfg_busy(cfg_busy), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish within time limit");
    $fatal(1, "timeout");
  end

  function automatic logic [1:0] fval(input logic [7:0] a);
    return a[7:6] ^ a[1:0];
  endfunction

  task automatic wr(input logic [7:0] a, input logic [1:0] d);
    cfg_wr_en = 1'b1; cfg_addr = a; cfg_data = d; tbl[a] = d;
    @(negedge clk);
    cfg_wr_en = 1'b0;
  endtask

  task automatic commit();
    cfg_commit = 1'b1;
    @(negedge clk);
    cfg_commit = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    s_valid = 1'b1;
    #1;
    checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL reset_s_ready got %b exp 0", s_ready); end
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL reset_m_valid got %b exp 0", m_valid); end
    checks++; if (m_data !== 2'b00) begin errors++; $display("FAIL reset_m_data got %b exp 00", m_data); end
    checks++; if (cfg_busy !== 1'b1) begin errors++; $display("FAIL reset_busy got %b exp 1", cfg_busy); end
    checks++; if (cfg_err !== 1'b0) begin errors++; $display("FAIL reset_err got %b exp 0", cfg_err); end
    s_valid = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_short_load();
    for (int i = 0; i < 255; i++) wr(8'(i), fval(8'(i)));
    checks++; if (cfg_busy !== 1'b1) begin errors++; $display("FAIL short_busy_load got %b exp 1", cfg_busy); end
    commit();
    s_valid = 1'b1;
    #1;
    checks++; if (cfg_err !== 1'b1) begin errors++; $display("FAIL short_err got %b exp 1", cfg_err); end
    checks++; if (cfg_busy !== 1'b1) begin errors++; $display("FAIL short_busy got %b exp 1", cfg_busy); end
    checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL short_s_ready got %b exp 0", s_ready); end
    s_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_full_load();
    for (int i = 0; i < 256; i++) wr(8'(i), fval(8'(i)));
    commit();
    #1;
    checks++; if (cfg_busy !== 1'b0) begin errors++; $display("FAIL full_busy got %b exp 0", cfg_busy); end
    checks++; if (cfg_err !== 1'b1) begin errors++; $display("FAIL full_err_sticky got %b exp 1", cfg_err); end
    checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL full_s_ready got %b exp 1", s_ready); end
    @(negedge clk);
  endtask

  task automatic test_stream();
    int rx = 0;
    m_ready = 1'b1;
    for (int cyc = 0; cyc < 260; cyc++) begin
      if (m_valid) begin
        if (rx == 0) begin
          checks++; if (cyc != 2) begin errors++; $display("FAIL stream_latency got cycle %0d exp 2", cyc); end
        end
        checks++;
        if (m_data !== tbl[rx]) begin errors++; $display("FAIL stream_data idx %0d got %b exp %b", rx, m_data, tbl[rx]); end
        rx++;
      end else if (rx > 0 && rx < 256) begin
        checks++; errors++; $display("FAIL stream_gap at cycle %0d got m_valid 0 exp 1", cyc);
      end
      if (cyc < 256) begin s_valid = 1'b1; s_data = 8'(cyc); end else s_valid = 1'b0;
      @(negedge clk);
    end
    checks++; if (rx != 256) begin errors++; $display("FAIL stream_count got %0d exp 256", rx); end
  endtask

  task automatic test_backpressure();
    logic [1:0] exp_bp [3];
    int rx = 0;
    exp_bp[0] = 2'b10; exp_bp[1] = 2'b01; exp_bp[2] = 2'b00;
    wr(8'h00, 2'b10); wr(8'h40, 2'b01); wr(8'h80, 2'b00);
    commit();
    checks++; if (cfg_busy !== 1'b0) begin errors++; $display("FAIL bp_update_busy got %b exp 0", cfg_busy); end
    m_ready = 1'b0;
    s_valid = 1'b1; s_data = 8'h00; @(negedge clk);
    s_data = 8'h40; @(negedge clk);
    s_data = 8'h80;
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++; if (m_valid !== 1'b1) begin errors++; $display("FAIL bp_hold_valid cyc %0d got %b exp 1", i, m_valid); end
      checks++; if (m_data !== 2'b10) begin errors++; $display("FAIL bp_hold_data cyc %0d got %b exp 10", i, m_data); end
      checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL bp_hold_s_ready cyc %0d got %b exp 0", i, s_ready); end
      @(negedge clk);
    end
    m_ready = 1'b1;
    for (int cyc = 0; cyc < 6; cyc++) begin
      #1;
      if (cyc == 0) begin
        checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL bp_release_s_ready got %b exp 1", s_ready); end
      end
      if (m_valid) begin
        checks++;
        if (rx > 2) begin errors++; $display("FAIL bp_extra_word got %b exp none", m_data); end
        else if (m_data !== exp_bp[rx]) begin errors++; $display("FAIL bp_order idx %0d got %b exp %b", rx, m_data, exp_bp[rx]); end
        rx++;
      end
      @(negedge clk);
      s_valid = 1'b0;
    end
    checks++; if (rx != 3) begin errors++; $display("FAIL bp_count got %0d exp 3", rx); end
  endtask

  task automatic test_partial_update();
    logic [7:0] q [3];
    int rx = 0;
    q[0] = 8'h32; q[1] = 8'h33; q[2] = 8'h34;
    m_ready = 1'b1;
    s_valid = 1'b1; s_data = 8'h32; @(negedge clk);
    s_data = 8'h33; cfg_wr_en = 1'b1; cfg_addr = 8'h33; cfg_data = 2'b11; tbl[8'h33] = 2'b11;
    #1;
    checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL pu_s_ready_fall got %b exp 0", s_ready); end
    @(negedge clk);
    cfg_wr_en = 1'b0; s_valid = 1'b0; cfg_commit = 1'b1;
    #1;
    checks++; if (cfg_busy !== 1'b1) begin errors++; $display("FAIL pu_busy_load got %b exp 1", cfg_busy); end
    checks++; if (m_valid !== 1'b1 || m_data !== 2'b10) begin errors++; $display("FAIL pu_drain got v%b d%b exp v1 d10", m_valid, m_data); end
    @(negedge clk);
    cfg_commit = 1'b0;
    checks++; if (cfg_busy !== 1'b0) begin errors++; $display("FAIL pu_commit_busy got %b exp 0", cfg_busy); end
    for (int cyc = 0; cyc < 6; cyc++) begin
      #1;
      if (m_valid) begin
        checks++;
        if (rx > 2) begin errors++; $display("FAIL pu_extra_word got %b exp none", m_data); end
        else if (m_data !== tbl[q[rx]]) begin errors++; $display("FAIL pu_lookup addr %h got %b exp %b", q[rx], m_data, tbl[q[rx]]); end
        rx++;
      end
      if (cyc < 3) begin s_valid = 1'b1; s_data = q[cyc]; end else s_valid = 1'b0;
      @(negedge clk);
    end
    checks++; if (rx != 3) begin errors++; $display("FAIL pu_count got %0d exp 3", rx); end
  endtask

  task automatic test_reset_midstream();
    logic [7:0] q [4];
    logic [1:0] e [4];
    int rx = 0;
    q[0] = 8'h33; q[1] = 8'h34; q[2] = 8'h40; q[3] = 8'hC5;
    e[0] = 2'b11; e[1] = 2'b00; e[2] = 2'b01; e[3] = 2'b10;
    m_ready = 1'b1;
    s_valid = 1'b1; s_data = 8'h33; @(negedge clk);
    s_data = 8'h34; @(negedge clk);
    s_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_m_valid got %b exp 0", m_valid); end
    checks++; if (cfg_busy !== 1'b1) begin errors++; $display("FAIL rst_mid_busy got %b exp 1", cfg_busy); end
    checks++; if (cfg_err !== 1'b0) begin errors++; $display("FAIL rst_mid_err got %b exp 0", cfg_err); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_flushed got %b exp 0", m_valid); end
    // 256 writes to a single address still satisfy a full load; the last lands with the commit.
    for (int i = 0; i < 255; i++) wr(8'h00, tbl[8'h00]);
    cfg_wr_en = 1'b1; cfg_addr = 8'h00; cfg_data = tbl[8'h00]; cfg_commit = 1'b1;
    @(negedge clk);
    cfg_wr_en = 1'b0; cfg_commit = 1'b0;
    checks++; if (cfg_busy !== 1'b0) begin errors++; $display("FAIL rst_mid_reload_busy got %b exp 0", cfg_busy); end
    checks++; if (cfg_err !== 1'b0) begin errors++; $display("FAIL rst_mid_reload_err got %b exp 0", cfg_err); end
    for (int cyc = 0; cyc < 7; cyc++) begin
      #1;
      if (m_valid) begin
        checks++;
        if (rx > 3) begin errors++; $display("FAIL rst_mid_extra got %b exp none", m_data); end
        else if (m_data !== e[rx]) begin errors++; $display("FAIL rst_mid_lookup addr %h got %b exp %b", q[rx], m_data, e[rx]); end
        rx++;
      end
      if (cyc < 4) begin s_valid = 1'b1; s_data = q[cyc]; end else s_valid = 1'b0;
      @(negedge clk);
    end
    checks++; if (rx != 4) begin errors++; $display("FAIL rst_mid_count got %0d exp 4", rx); end
  endtask

  initial begin
    rst_n = 1'b0; s_valid = 1'b0; s_data = '0; m_ready = 1'b1;
    cfg_wr_en = 1'b0; cfg_addr = '0; cfg_data = '0; cfg_commit = 1'b0;
    test_reset();
    test_short_load();
    test_full_load();
    test_stream();
    test_backpressure();
    test_partial_update();
    test_reset_midstream();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
